systolic_output_collector: RTL and testbench

// Downstream of the weight-stationary matmul FSM. Captures skewed per-column bottom_out words (qualified by output_col_valid), de-skews them into a ROWS x COLS result buffer, and writes one row per memory transaction to the output matrix region.

---
 rtl/systolic_output_collector.sv | 156 +++++++++++++++
 tb/tb_systolic_output_collector.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_output_collector.sv
// Collects skewed per-column systolic outputs into a ROWS x COLS buffer and writes
// the buffer out one row per memory transaction, handshaking with the matmul FSM.
module systolic_output_collector #(
  parameter int          ROWS               = 4,
  parameter int          COLS               = 4,
  parameter int          WORD_SIZE          = 16,
  parameter int          MEM_PORT_WIDTH     = 64,
  parameter int          MEM_ACCESS_LATENCY = 2,
  parameter logic [31:0] OUT_BASE_ADDR      = 32'h200,
  parameter int          ADDR_INCR          = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [COLS*WORD_SIZE-1:0] matmul_output,
  input  logic [COLS-1:0]           output_col_valid,
  input  logic                      fsm_done,
  output logic                      wr_output_rdy,
  output logic                      wr_output_done,
  output logic [31:0]               mem_addr,
  output logic                      mem_wr_en,
  output logic [MEM_PORT_WIDTH-1:0] mem_wr_data,
  output logic                      busy,
  output logic                      err_incomplete
);
  localparam int CW = $clog2(ROWS) + 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int DW = (MEM_ACCESS_LATENCY > 1) ? $clog2(MEM_ACCESS_LATENCY) : 1;
  localparam int RD = COLS * WORD_SIZE;

  typedef enum logic [2:0] {S_IDLE, S_CAPTURE, S_WRITE, S_WAIT, S_DONE} state_t;

  state_t                                   state_q, state_d;
  logic [ROWS-1:0][COLS-1:0][WORD_SIZE-1:0] rbuf_q, rbuf_d;
  logic [COLS-1:0][CW-1:0]                  cnt_q, cnt_d;
  logic [RW-1:0]                            row_q, row_d;
  logic [DW-1:0]                            dly_q, dly_d;
  logic                                     done_seen_q, done_seen_d;
  logic                                     idle_q, idle_d;
  logic                                     err_q, err_d;
  logic [31:0]                              addr_q, addr_d;
  logic [MEM_PORT_WIDTH-1:0]                data_q, data_d;
  logic                                     cap_en, all_full, any_vld, done_now, adv;

  always_comb begin
    state_d     = state_q;
    rbuf_d      = rbuf_q;
    cnt_d       = cnt_q;
    row_d       = row_q;
    dly_d       = dly_q;
    done_seen_d = done_seen_q;
    idle_d      = idle_q;
    err_d       = err_q;
    addr_d      = addr_q;
    data_d      = data_q;
    adv         = 1'b0;
    cap_en      = (state_q == S_IDLE) || (state_q == S_CAPTURE);
    any_vld     = |output_col_valid;
    done_now    = done_seen_q | fsm_done;

    // Columns fill independently, so any input skew lands in the right row.
    for (int c = 0; c < COLS; c++) begin
      if (cap_en && output_col_valid[c] && (cnt_q[c] < CW'(ROWS))) begin
        rbuf_d[cnt_q[c][RW-1:0]][c] = matmul_output[c*WORD_SIZE +: WORD_SIZE];
        cnt_d[c] = cnt_q[c] + CW'(1);
      end
    end
    all_full = 1'b1;
    for (int c = 0; c < COLS; c++) begin
      if (cnt_d[c] != CW'(ROWS)) all_full = 1'b0;
    end

    case (state_q)
      S_IDLE: if (any_vld) state_d = S_CAPTURE;
      S_CAPTURE: begin
        if (fsm_done) done_seen_d = 1'b1;
        idle_d = done_now & ~any_vld;
        if (all_full && done_now) begin
          state_d = S_WRITE;
          row_d   = '0;
        end else if (done_now && !any_vld && idle_q) begin
          err_d   = 1'b1;
          state_d = S_WRITE;
          row_d   = '0;
        end
      end
      S_WRITE: begin
        dly_d = DW'(MEM_ACCESS_LATENCY - 1);
        if (MEM_ACCESS_LATENCY == 1) adv = 1'b1;
        else state_d = S_WAIT;
      end
      // dly counts the remaining access cycles; the last one hands off to the next row.
      S_WAIT: begin
        if (dly_q == DW'(1)) adv = 1'b1;
        else dly_d = dly_q - DW'(1);
      end
      S_DONE: begin
        rbuf_d      = '0;
        cnt_d       = '0;
        done_seen_d = 1'b0;
        idle_d      = 1'b0;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (adv) begin
      if (row_q == RW'(ROWS - 1)) state_d = S_DONE;
      else begin
        row_d   = row_q + RW'(1);
        state_d = S_WRITE;
      end
    end

    // Address/data are loaded on entry to WRITE from the post-capture buffer and held.
    if (state_d == S_WRITE) begin
      addr_d         = OUT_BASE_ADDR + 32'(row_d) * 32'(ADDR_INCR);
      data_d         = '0;
      data_d[RD-1:0] = rbuf_d[row_d];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rbuf_q      <= '0;
      cnt_q       <= '0;
      row_q       <= '0;
      dly_q       <= '0;
      done_seen_q <= 1'b0;
      idle_q      <= 1'b0;
      err_q       <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
    end else begin
      state_q     <= state_d;
      rbuf_q      <= rbuf_d;
      cnt_q       <= cnt_d;
      row_q       <= row_d;
      dly_q       <= dly_d;
      done_seen_q <= done_seen_d;
      idle_q      <= idle_d;
      err_q       <= err_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
    end
  end

  assign wr_output_rdy  = (state_q == S_IDLE);
  assign wr_output_done = (state_q == S_DONE);
  assign mem_wr_en      = (state_q == S_WRITE);
  assign busy           = (state_q != S_IDLE);
  assign mem_addr       = addr_q;
  assign mem_wr_data    = data_q;
  assign err_incomplete = err_q;

endmodule

// File: tb/tb_systolic_output_collector.sv
// Scoreboard bench for systolic_output_collector: table of skew scenarios plus
// hand-written reset-abort and single-cycle-latency sequences.
module tb_systolic_output_collector;
  localparam int R = 4, C = 4, W = 16, MPW = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst0_n, rst1_n, fdone;
  logic [C*W-1:0]   mo;
  logic [C-1:0]     vld;
  logic             rdy0, done0, en0, busy0, err0, rdy1, done1, en1, busy1, err1;
  logic [31:0]      addr0, addr1;
  logic [MPW-1:0]   data0, data1;

  systolic_output_collector #(.MEM_ACCESS_LATENCY(2)) u0 (
    .clk(clk), .rst_n(rst0_n), .matmul_output(mo), .output_col_valid(vld), .fsm_done(fdone),
    .wr_output_rdy(rdy0), .wr_output_done(done0), .mem_addr(addr0), .mem_wr_en(en0),
    .mem_wr_data(data0), .busy(busy0), .err_incomplete(err0));

  systolic_output_collector #(.MEM_ACCESS_LATENCY(1)) u1 (
    .clk(clk), .rst_n(rst1_n), .matmul_output(mo), .output_col_valid(vld), .fsm_done(fdone),
    .wr_output_rdy(rdy1), .wr_output_done(done1), .mem_addr(addr1), .mem_wr_en(en1),
    .mem_wr_data(data1), .busy(busy1), .err_incomplete(err1));

  bit sel;
  logic m_rdy, m_done, m_en, m_busy, m_err;
  logic [31:0] m_addr;
  logic [MPW-1:0] m_data;
  assign m_rdy  = sel ? rdy1  : rdy0;
  assign m_done = sel ? done1 : done0;
  assign m_en   = sel ? en1   : en0;
  assign m_busy = sel ? busy1 : busy0;
  assign m_err  = sel ? err1  : err0;
  assign m_addr = sel ? addr1 : addr0;
  assign m_data = sel ? data1 : data0;

  typedef struct packed {
    logic [3:0][3:0] skew;
    logic [3:0][2:0] nsamp;
    logic [1:0]      extra;
    logic            dwl;    // fsm_done together with the last valid sample
    logic [15:0]     base;
  } vec_t;

  int errors = 0, checks = 0, cyc = 0;
  int lat, nstrobe, first_cyc, last_cyc, ndone;
  bit prev_done, err_exp;
  logic [95:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [95:0] e;
    if (prev_done) begin
      chk("rdy_after_done", 64'(m_rdy), 64'd1);
      chk("busy_after_done", 64'(m_busy), 64'd0);
    end
    prev_done = m_done;
    if (m_en) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_strobe: addr %h, no write expected", m_addr);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", 64'(m_addr), 64'(e[95:64]));
        chk("wr_data", m_data, e[63:0]);
      end
      if (nstrobe > 0) chk("strobe_gap", 64'(cyc - last_cyc), 64'(lat));
      else first_cyc = cyc;
      nstrobe++;
      last_cyc = cyc;
    end
    if (m_done) begin
      chk("done_gap", 64'(cyc - last_cyc), 64'(lat));
      chk("strobe_count", 64'(nstrobe), 64'(R));
      ndone++;
    end
  end

  task automatic drive_vec(input vec_t v, output int exp_first);
    int last_t, done_t, k, tot;
    bit inc;
    logic [63:0] d;
    logic [15:0] w;
    nstrobe = 0; ndone = 0; first_cyc = -1;
    last_t = 0; inc = 0;
    for (int c = 0; c < C; c++) begin
      tot = int'(v.skew[c]) + int'(v.nsamp[c]) + int'(v.extra) - 1;
      if (tot > last_t) last_t = tot;
      if (int'(v.nsamp[c]) < R) inc = 1;
    end
    for (int r = 0; r < R; r++) begin
      d = '0;
      for (int c = 0; c < C; c++)
        if (r < int'(v.nsamp[c])) d[c*W +: W] = 16'(int'(v.base) + 16*r + c);
      exp_q.push_back({32'(32'h200 + 4*r), d});
    end
    done_t = v.dwl ? last_t : last_t + 1;
    exp_first = 0;
    for (int t = 0; t <= done_t; t++) begin
      vld = '0; mo = '0;
      for (int c = 0; c < C; c++) begin
        k = t - int'(v.skew[c]);
        if (k >= 0 && k < int'(v.nsamp[c]) + int'(v.extra)) begin
          vld[c] = 1'b1;
          w = (k < int'(v.nsamp[c])) ? 16'(int'(v.base) + 16*k + c) : 16'hDEAD;
          mo[c*W +: W] = w;
        end
      end
      fdone = (t == done_t);
      if (t == done_t) exp_first = cyc + (inc ? 2 : 1);
      @(posedge clk); #1;
    end
    vld = '0; mo = '0;
    err_exp |= inc;
  endtask

  task automatic finish_vec(input int exp_first);
    int n;
    n = 0;
    while (ndone == 0 && n < 200) begin @(posedge clk); #1; n++; end
    if (ndone == 0) begin
      checks++; errors++;
      $display("FAIL done_timeout: no wr_output_done within %0d cycles", n);
    end
    fdone = 1'b0;
    chk("first_strobe_cycle", 64'(first_cyc), 64'(exp_first));
    chk("err_incomplete", 64'(m_err), 64'(err_exp));
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("done_pulses", 64'(ndone), 64'd1);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_rdy", 64'(m_rdy), 64'd1);
    chk("rst_done", 64'(m_done), 64'd0);
    chk("rst_wr_en", 64'(m_en), 64'd0);
    chk("rst_addr", 64'(m_addr), 64'd0);
    chk("rst_data", m_data, 64'd0);
    chk("rst_busy", 64'(m_busy), 64'd0);
    chk("rst_err", 64'(m_err), 64'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vt[5];
    int ef, n;
    vt[0] = '{skew: {4'd3, 4'd2, 4'd1, 4'd0}, nsamp: {3'd4, 3'd4, 3'd4, 3'd4}, extra: 2'd0, dwl: 1'b0, base: 16'h0000};
    vt[1] = '{skew: {4'd3, 4'd2, 4'd1, 4'd0}, nsamp: {3'd4, 3'd4, 3'd4, 3'd4}, extra: 2'd1, dwl: 1'b0, base: 16'h0000};
    vt[2] = '{skew: {4'd1, 4'd2, 4'd0, 4'd3}, nsamp: {3'd4, 3'd4, 3'd4, 3'd4}, extra: 2'd0, dwl: 1'b1, base: 16'h0040};
    vt[3] = '{skew: {4'd0, 4'd0, 4'd0, 4'd0}, nsamp: {3'd4, 3'd4, 3'd4, 3'd4}, extra: 2'd0, dwl: 1'b0, base: 16'h0080};
    vt[4] = '{skew: {4'd3, 4'd2, 4'd1, 4'd0}, nsamp: {3'd2, 3'd4, 3'd4, 3'd4}, extra: 2'd0, dwl: 1'b0, base: 16'h0000};

    sel = 0; lat = 2; err_exp = 0; prev_done = 0;
    nstrobe = 0; ndone = 0; first_cyc = -1; last_cyc = 0;
    rst0_n = 0; rst1_n = 0; vld = '0; mo = '0; fdone = 0;
    repeat (2) @(posedge clk);
    #1 rst0_n = 1;
    @(negedge clk);
    chk_reset_outputs();

    // fsm_done alone in IDLE must not start anything
    @(posedge clk); #1 fdone = 1;
    repeat (4) @(posedge clk);
    #1;
    chk("idle_fsm_done_busy", 64'(m_busy), 64'd0);
    chk("idle_fsm_done_rdy", 64'(m_rdy), 64'd1);
    fdone = 0;
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++) begin
      drive_vec(vt[i], ef);
      finish_vec(ef);
    end

    // abort mid-transfer: reset during the wait after row 1
    drive_vec(vt[0], ef);
    n = 0;
    while (nstrobe < 2 && n < 200) begin @(posedge clk); #1; n++; end
    if (nstrobe < 2) begin
      checks++; errors++;
      $display("FAIL abort_timeout: saw %0d strobes, needed 2", nstrobe);
    end
    chk("abort_busy_before_reset", 64'(m_busy), 64'd1);
    rst0_n = 0; fdone = 0;
    @(posedge clk);
    @(negedge clk);
    chk_reset_outputs();
    exp_q.delete();
    err_exp = 0;
    @(posedge clk); #1 rst0_n = 1;
    repeat (6) @(posedge clk);
    #1;
    chk("abort_no_more_strobes", 64'(nstrobe), 64'd2);
    drive_vec(vt[0], ef);
    finish_vec(ef);

    // single-cycle access latency instance
    rst0_n = 0; rst1_n = 1; sel = 1; lat = 1; err_exp = 0; prev_done = 0;
    @(posedge clk); #1;
    drive_vec(vt[0], ef);
    finish_vec(ef);
    drive_vec(vt[2], ef);
    finish_vec(ef);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
